// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one synchronous RAM between the cpu fetch and data ports.
// Per-port grant counters are built only when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iGnt,
  output logic              iValid,
  output logic [DATA_W-1:0] iData,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWriteData,
  output logic              dGnt,
  output logic              dValid,
  output logic [DATA_W-1:0] dReadData,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData,
  output logic              cpuStall,
  output logic [31:0]       iGntCount,
  output logic [31:0]       dGntCount
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : gLatCheck
    $error("mem_port_arbiter: MEM_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_t     state, nextState;
  logic [1:0] waitCnt, nextWaitCnt;
  logic       ownerData, nextOwnerData;
  logic       lastGntData;
  logic       issueNext, issueStore, respNext, captureRead;

  // Next-state, round-robin arbitration and read-wait countdown.
  always_comb begin
    nextState     = state;
    nextWaitCnt   = waitCnt;
    nextOwnerData = ownerData;
    case (state)
      IDLE: begin
        if (iReq || dReq) begin
          nextState     = ISSUE;
          nextOwnerData = dReq && (!iReq || !lastGntData);
        end else begin
          nextState = IDLE;
        end
      end
      ISSUE: begin
        // memWe is high during ISSUE exactly when the access is a store
        if (memWe) begin
          nextState = RESP;
        end else begin
          nextState   = WAIT;
          nextWaitCnt = WAIT_INIT;
        end
      end
      WAIT: begin
        if (waitCnt == 2'd0) begin
          nextState = RESP;
        end else begin
          nextWaitCnt = waitCnt - 2'd1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign issueNext   = (nextState == ISSUE);
  assign issueStore  = issueNext && nextOwnerData && dWe;
  assign respNext    = (nextState == RESP);
  assign captureRead = (state == WAIT) && respNext;
  assign cpuStall    = (iReq || dReq || (state != IDLE)) && (state != RESP);

  // State, current owner and last-granted history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      waitCnt     <= 2'd0;
      ownerData   <= 1'b0;
      lastGntData <= 1'b1;
    end else begin
      state     <= nextState;
      waitCnt   <= nextWaitCnt;
      ownerData <= nextOwnerData;
      if (state == ISSUE) begin
        lastGntData <= ownerData;
      end
    end
  end

  // Port and memory strobes registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iGnt         <= 1'b0;
      dGnt         <= 1'b0;
      iValid       <= 1'b0;
      dValid       <= 1'b0;
      memEn        <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= {ADDR_W{1'b0}};
      memWriteData <= {DATA_W{1'b0}};
      iData        <= {DATA_W{1'b0}};
      dReadData    <= {DATA_W{1'b0}};
    end else begin
      iGnt         <= issueNext && !nextOwnerData;
      dGnt         <= issueNext && nextOwnerData;
      iValid       <= respNext && !nextOwnerData;
      dValid       <= respNext && nextOwnerData;
      memEn        <= issueNext;
      memWe        <= issueStore;
      memAddr      <= issueNext ? (nextOwnerData ? dAddr : iAddr) : {ADDR_W{1'b0}};
      memWriteData <= issueStore ? dWriteData : {DATA_W{1'b0}};
      if (captureRead && !ownerData) begin
        iData <= memReadData;
      end
      if (captureRead && ownerData) begin
        dReadData <= memReadData;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] iGntCountR, dGntCountR;

  // Free-running grant counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iGntCountR <= 32'd0;
      dGntCountR <= 32'd0;
    end else begin
      if (iGnt) begin
        iGntCountR <= iGntCountR + 32'd1;
      end
      if (dGnt) begin
        dGntCountR <= dGntCountR + 32'd1;
      end
    end
  end

  assign iGntCount = iGntCountR;
  assign dGntCount = dGntCountR;
`else
  assign iGntCount = 32'd0;
  assign dGntCount = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1, 3, 4) checked every cycle against a
// transaction-timeline model, plus directed vector table, reset-abort and round-robin sequences.
module tb_mem_port_arbiter;
  localparam int NI = 3;

  typedef struct {
    int          k;
    logic        iR, dR, we;
    logic [31:0] iA, dA, wd;
    logic        eD, eWe;
    int          eV;
    logic [31:0] eData;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        iReq [NI], dReq [NI], dWe [NI];
  logic [31:0] iAddr [NI], dAddr [NI], dWriteData [NI], memReadData [NI];
  logic        iGnt [NI], iValid [NI], dGnt [NI], dValid [NI], memEn [NI], memWe [NI], cpuStall [NI];
  logic [31:0] iData [NI], dReadData [NI], memAddr [NI], memWriteData [NI], iGntCount [NI], dGntCount [NI];
  int compared = 0;
  int mismatched = 0;
  bit chkEn = 1'b0;
  vec_t tbl [8];

  always #5 clk = ~clk;

  // Contents of the stub RAM: fixed words at the addresses the directed cases use, hash elsewhere.
  function automatic logic [31:0] memData(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00000093;
      32'h20:  return 32'hABCDE000;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endcase
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int k, input logic iR, input logic dR, input logic we,
                              input logic [31:0] iA, input logic [31:0] dA, input logic [31:0] wd,
                              input logic eD, input logic eWe, input int eV, input logic [31:0] eData);
    vec_t v;
    v.k = k; v.iR = iR; v.dR = dR; v.we = we; v.iA = iA; v.dA = dA; v.wd = wd;
    v.eD = eD; v.eWe = eWe; v.eV = eV; v.eData = eData;
    return v;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [31:0] rdPipe [4];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
      .clk(clk), .reset(reset),
      .iReq(iReq[g]), .iAddr(iAddr[g]), .iGnt(iGnt[g]), .iValid(iValid[g]), .iData(iData[g]),
      .dReq(dReq[g]), .dWe(dWe[g]), .dAddr(dAddr[g]), .dWriteData(dWriteData[g]),
      .dGnt(dGnt[g]), .dValid(dValid[g]), .dReadData(dReadData[g]),
      .memEn(memEn[g]), .memWe(memWe[g]), .memAddr(memAddr[g]), .memWriteData(memWriteData[g]),
      .memReadData(memReadData[g]), .cpuStall(cpuStall[g]),
      .iGntCount(iGntCount[g]), .dGntCount(dGntCount[g])
    );

    // RAM stub: read word appears L cycles after memEn, garbage otherwise.
    always @(posedge clk) begin
      rdPipe[0] <= (memEn[g] && !memWe[g]) ? memData(memAddr[g]) : $urandom;
      for (int j = 1; j < 4; j++) rdPipe[j] <= rdPipe[j-1];
    end
    assign memReadData[g] = rdPipe[L-1];

    // Timeline model: one transaction at a time, described by its offset from the grant cycle.
    bit          act = 1'b0, ownD = 1'b0, st = 1'b0, lastD = 1'b1;
    int          off = 0, dur = 0;
    logic [31:0] a = 32'd0, wd = 32'd0, eI = 32'd0, eD = 32'd0, nI = 32'd0, nD = 32'd0;

    initial begin
      forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
          act = 1'b0; lastD = 1'b1; eI = 32'd0; eD = 32'd0; nI = 32'd0; nD = 32'd0;
        end else if (act) begin
          if (off == 0) begin
            if (ownD) nD++; else nI++;
          end
          off++;
          if (off == dur && !st) begin
            if (ownD) eD = memData(a); else eI = memData(a);
          end
          if (off > dur) act = 1'b0;
        end else if (iReq[g] || dReq[g]) begin
          ownD  = dReq[g] && (!iReq[g] || !lastD);
          lastD = ownD;
          st    = ownD && dWe[g];
          a     = ownD ? dAddr[g] : iAddr[g];
          wd    = dWriteData[g];
          dur   = st ? 1 : L + 1;
          off   = 0;
          act   = 1'b1;
        end
      end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
      if (chkEn) begin
        logic eG, eV, eW;
        eG = act && (off == 0);
        eV = act && (off == dur);
        eW = eG && st;
        check("iGnt", g, iGnt[g], eG && !ownD);
        check("dGnt", g, dGnt[g], eG && ownD);
        check("iValid", g, iValid[g], eV && !ownD);
        check("dValid", g, dValid[g], eV && ownD);
        check("memEn", g, memEn[g], eG);
        check("memWe", g, memWe[g], eW);
        check("memWriteData", g, memWriteData[g], eW ? wd : 32'd0);
        if (eG) check("memAddr", g, memAddr[g], a);
        check("cpuStall", g, cpuStall[g], act ? (off != dur) : (iReq[g] || dReq[g]));
        check("iData", g, iData[g], eI);
        check("dReadData", g, dReadData[g], eD);
`ifdef ARB_PERF_CNT_EN
        check("iGntCount", g, iGntCount[g], nI);
        check("dGntCount", g, dGntCount[g], nD);
`else
        check("iGntCount", g, iGntCount[g], 32'd0);
        check("dGntCount", g, dGntCount[g], 32'd0);
`endif
      end
    end
  end

  task automatic settle();
    repeat (10) @(posedge clk);
  endtask

  task automatic runVec(input vec_t v);
    int gCyc = -1, vCyc = -1;
    logic gD = 1'b0, enG = 1'b0, weG = 1'b0;
    logic [31:0] wdG = 32'd0, adG = 32'd0, data = 32'd0;
    logic [15:0] lowMask = 16'd0;
    @(posedge clk); #1;
    iReq[v.k] = v.iR; dReq[v.k] = v.dR; dWe[v.k] = v.we;
    iAddr[v.k] = v.iA; dAddr[v.k] = v.dA; dWriteData[v.k] = v.wd;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!cpuStall[v.k]) lowMask[c] = 1'b1;
      if ((iGnt[v.k] || dGnt[v.k]) && gCyc < 0) begin
        gCyc = c; gD = dGnt[v.k]; enG = memEn[v.k]; weG = memWe[v.k];
        wdG = memWriteData[v.k]; adG = memAddr[v.k];
        iReq[v.k] = 1'b0; dReq[v.k] = 1'b0;
      end
      if (iValid[v.k] || dValid[v.k]) begin
        vCyc = c;
        data = dValid[v.k] ? dReadData[v.k] : iData[v.k];
        break;
      end
    end
    iReq[v.k] = 1'b0; dReq[v.k] = 1'b0;
    check("vecGntCycle", v.k, gCyc, 1);
    check("vecOwner", v.k, gD, v.eD);
    check("vecMemEn", v.k, enG, 1'b1);
    check("vecMemWe", v.k, weG, v.eWe);
    check("vecMemWd", v.k, wdG, v.eWe ? v.wd : 32'd0);
    check("vecMemAddr", v.k, adG, v.eD ? v.dA : v.iA);
    check("vecValidCycle", v.k, vCyc, v.eV);
    check("vecData", v.k, data, v.eData);
    check("vecStallLow", v.k, lowMask, 32'd1 << v.eV);
  endtask

  task automatic tieRun(input int k, input int n);
    int got = 0, cyc = 0;
    logic expD = 1'b0;
    @(posedge clk); #1;
    iReq[k] = 1'b1; dReq[k] = 1'b1; dWe[k] = 1'b0; iAddr[k] = 32'h100; dAddr[k] = 32'h200;
    while (got < n && cyc < 20 * n) begin
      @(negedge clk);
      cyc++;
      if (iGnt[k] || dGnt[k]) begin
        check("tieOwner", k, dGnt[k], expD);
        expD = !expD;
        got++;
      end
    end
    check("tieGrants", k, got, n);
    iReq[k] = 1'b0; dReq[k] = 1'b0;
  endtask

  initial begin
    int cyc, vals;
    for (int k = 0; k < NI; k++) begin
      iReq[k] = 1'b0; dReq[k] = 1'b0; dWe[k] = 1'b0;
      iAddr[k] = 32'd0; dAddr[k] = 32'd0; dWriteData[k] = 32'd0;
    end
    tbl[0] = mk(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 3, 32'h00000093);
    tbl[1] = mk(0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h01FE, 1'b1, 1'b1, 2, 32'h0);
    tbl[2] = mk(2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 1'b1, 1'b0, 6, 32'hABCDE000);
    tbl[3] = mk(0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 1'b1, 1'b0, 3, memData(32'h44));
    tbl[4] = mk(1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 5, memData(32'h1234));
    tbl[5] = mk(0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h8, 32'hDEADBEEF, 1'b1, 1'b1, 2, memData(32'h44));
    tbl[6] = mk(2, 1'b0, 1'b1, 1'b1, 32'h0, 32'h3C, 32'h5, 1'b1, 1'b1, 2, 32'hABCDE000);
    tbl[7] = mk(0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 32'hFFFF, 1'b0, 1'b0, 3, memData(32'h30));

    #12 chkEn = 1'b1;
    @(negedge clk); #2 reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      settle();
      runVec(tbl[i]);
    end

    // Abort a fetch on the MEM_LAT=3 instance while it waits for read data.
    settle();
    @(posedge clk); #1;
    iReq[1] = 1'b1; iAddr[1] = 32'h40;
    cyc = 0;
    while (!iGnt[1] && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("rstGnt", 1, iGnt[1], 1'b1);
    iReq[1] = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rstZeroGnt", k, {iGnt[k], dGnt[k], iValid[k], dValid[k]}, 32'd0);
      check("rstZeroMem", k, {memEn[k], memWe[k], cpuStall[k]}, 32'd0);
      check("rstZeroAddr", k, memAddr[k] | memWriteData[k], 32'd0);
      check("rstZeroData", k, iData[k] | dReadData[k], 32'd0);
      check("rstZeroCnt", k, iGntCount[k] | dGntCount[k], 32'd0);
    end
    @(negedge clk); #2 reset = 1'b0;
    vals = 0;
    repeat (8) begin
      @(negedge clk);
      if (iValid[1] || dValid[1]) vals++;
    end
    check("rstNoValid", 1, vals, 0);

    tieRun(1, 2);
    settle();
    tieRun(0, 4);
    settle();
    tieRun(2, 2);
    settle();

    // Random requesters on all instances, checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        if (iGnt[k]) iReq[k] = 1'b0;
        else if (!iReq[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            iReq[k] = 1'b1; iAddr[k] = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) iReq[k] = 1'b0;
        if (dGnt[k]) dReq[k] = 1'b0;
        else if (!dReq[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            dReq[k] = 1'b1; dWe[k] = 1'($urandom_range(0, 1));
            dAddr[k] = $urandom_range(0, 255); dWriteData[k] = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) dReq[k] = 1'b0;
      end
    end
    for (int k = 0; k < NI; k++) begin
      iReq[k] = 1'b0; dReq[k] = 1'b0;
    end
    settle();
    chkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
